// File: rtl/fpu_host_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pa_fpu (package)                                           |
// | Purpose  : Shared types and register map for the byte-bus FPU and its |
// |            host sequencer.                                           |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package pa_fpu;

  // FPU operation codes as seen on register address 8
  typedef enum logic [3:0] {
    op_add = 4'd0,
    op_sub = 4'd1,
    op_mul = 4'd2,
    op_div = 4'd3
  } e_fpu_operation;

  // Host sequencer states
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_SETUP  = 4'd1,
    WR_STROBE = 4'd2,
    WR_HOLD   = 4'd3,
    WAIT_END  = 4'd4,
    SETTLE    = 4'd5,
    RD_SETUP  = 4'd6,
    RD_STROBE = 4'd7,
    RD_HOLD   = 4'd8,
    ACK       = 4'd9,
    WAIT_CLR  = 4'd10,
    RESP      = 4'd11
  } e_fpu_seq_state;

  // Phases of a single byte-bus access
  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_SETUP  = 2'd1,
    BUS_STROBE = 2'd2,
    BUS_HOLD   = 2'd3
  } e_bus_phase;

  // FPU register map
  localparam logic [3:0] FPU_ADDR_A0 = 4'd0;
  localparam logic [3:0] FPU_ADDR_B0 = 4'd4;
  localparam logic [3:0] FPU_ADDR_OP = 4'd8;
  localparam logic [3:0] FPU_ADDR_R0 = 4'd9;

  // Byte written at write index idx: A bytes 0..3, B bytes 4..7, opcode at 8
  function automatic logic [7:0] wr_byte(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op, input logic [3:0] idx);
    logic [7:0] res;
    if (idx < FPU_ADDR_B0)      res = a[{idx[1:0], 3'b000} +: 8];
    else if (idx < FPU_ADDR_OP) res = b[{idx[1:0], 3'b000} +: 8];
    else                        res = {4'b0000, op};
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_host_sequencer_bus_cycle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fpu_bus_cycle                                              |
// | Purpose  : One byte-bus access to the FPU: setup, strobe, hold, with  |
// |            read capture on the last strobe cycle.                     |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fpu_bus_cycle
  import pa_fpu::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       start,        // begin an access; honoured in idle or hold
  input  logic       is_read,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic       last_strobe,  // current cycle is the final strobe cycle
  output logic       done,         // access is in its hold cycle
  output logic [7:0] rdata,
  output logic [3:0] fpu_addr,
  output logic       fpu_cs,
  output logic       fpu_wr,
  output logic       fpu_rd,
  output logic [7:0] fpu_data_out,
  input  logic [7:0] fpu_data_in
);

  localparam logic [3:0] C_LAST = 4'(STROBE_CYCLES - 1);

  e_bus_phase phase_q, phase_d;
  logic [3:0] cnt_q, cnt_d;
  logic       read_q, read_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rdata_q, rdata_d;
  logic       cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;

  assign last_strobe  = (phase_q == BUS_STROBE) && (cnt_q == C_LAST);
  assign done         = (phase_q == BUS_HOLD);
  assign rdata        = rdata_q;
  assign fpu_addr     = addr_q;
  assign fpu_data_out = data_q;
  assign fpu_cs       = cs_q;
  assign fpu_wr       = wr_q;
  assign fpu_rd       = rd_q;

  // Next access phase; strobes are derived from the next phase so they come straight off flops
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    read_d  = read_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    case (phase_q)
      BUS_IDLE, BUS_HOLD: begin
        if (start) begin
          phase_d = BUS_SETUP;
          read_d  = is_read;
          addr_d  = addr;
          if (!is_read) data_d = wdata;
        end else begin
          phase_d = BUS_IDLE;
        end
      end
      BUS_SETUP: begin
        phase_d = BUS_STROBE;
        cnt_d   = 4'd0;
      end
      BUS_STROBE: begin
        if (cnt_q == C_LAST) begin
          phase_d = BUS_HOLD;
          if (read_q) rdata_d = fpu_data_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: phase_d = BUS_IDLE;
    endcase
    cs_d = (phase_d != BUS_STROBE);
    wr_d = !((phase_d == BUS_STROBE) && !read_d);
    rd_d = !((phase_d == BUS_STROBE) && read_d);
  end

  // Access state and registered bus outputs; reset parks strobes high at once
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      phase_q <= BUS_IDLE;
      cnt_q   <= 4'd0;
      read_q  <= 1'b0;
      addr_q  <= 4'd0;
      data_q  <= 8'd0;
      rdata_q <= 8'd0;
      cs_q    <= 1'b1;
      wr_q    <= 1'b1;
      rd_q    <= 1'b1;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_host_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fpu_host_sequencer                                         |
// | Purpose  : Turns a 32-bit FPU request into byte-bus writes, waits for |
// |            completion, reads the result and returns it.               |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fpu_host_sequencer
  import pa_fpu::*;
#(
  parameter int STROBE_CYCLES  = 2,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic [3:0]  fpu_addr,
  output logic        fpu_cs,
  output logic        fpu_wr,
  output logic        fpu_rd,
  output logic [7:0]  fpu_data_out,
  input  logic [7:0]  fpu_data_in,
  input  logic        fpu_cmd_end,
  output logic        fpu_end_ack
);

  // One counter serves both the settle delay and the timeout
  localparam int C_CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int C_TW      = $clog2(C_CNT_MAX + 1);
  localparam logic [C_TW-1:0] C_TMO_LAST    = C_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [C_TW-1:0] C_SETTLE_LAST = C_TW'(SETTLE_CYCLES - 1);

  e_fpu_seq_state state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [C_TW-1:0] tmo_q, tmo_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [3:0]      op_q, op_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_result_q, rsp_result_d;
  logic            end_ack_q, end_ack_d;

  logic            eng_start, eng_read, eng_last_strobe, eng_done;
  logic [3:0]      eng_addr;
  logic [7:0]      eng_wdata, eng_rdata;

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_result  = rsp_result_q;
  assign fpu_end_ack = end_ack_q;

  fpu_bus_cycle #(.STROBE_CYCLES(STROBE_CYCLES)) u_bus (
    .clk          (clk),
    .arst_n       (arst_n),
    .start        (eng_start),
    .is_read      (eng_read),
    .addr         (eng_addr),
    .wdata        (eng_wdata),
    .last_strobe  (eng_last_strobe),
    .done         (eng_done),
    .rdata        (eng_rdata),
    .fpu_addr     (fpu_addr),
    .fpu_cs       (fpu_cs),
    .fpu_wr       (fpu_wr),
    .fpu_rd       (fpu_rd),
    .fpu_data_out (fpu_data_out),
    .fpu_data_in  (fpu_data_in)
  );

  // Transaction sequencing; bus states track the access engine phase by phase
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    req_ready_d  = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_result_d = rsp_result_q;
    end_ack_d    = 1'b0;
    eng_start    = 1'b0;
    eng_read     = 1'b0;
    eng_addr     = FPU_ADDR_A0;
    eng_wdata    = 8'd0;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          a_d          = req_a;
          b_d          = req_b;
          op_d         = req_op;
          idx_d        = 4'd0;
          req_ready_d  = 1'b0;
          rsp_err_d    = 1'b0;
          rsp_result_d = 32'd0;
          eng_start    = 1'b1;
          eng_addr     = FPU_ADDR_A0;
          eng_wdata    = req_a[7:0];
          state_d      = WR_SETUP;
        end
      end
      WR_SETUP:  state_d = WR_STROBE;
      WR_STROBE: if (eng_last_strobe) state_d = WR_HOLD;
      WR_HOLD: begin
        if (eng_done) begin
          if (idx_q == FPU_ADDR_OP) begin
            state_d = WAIT_END;
            tmo_d   = '0;
          end else begin
            idx_d     = idx_q + 4'd1;
            eng_start = 1'b1;
            eng_addr  = FPU_ADDR_A0 + idx_d;
            eng_wdata = wr_byte(a_q, b_q, op_q, idx_d);
            state_d   = WR_SETUP;
          end
        end
      end
      WAIT_END: begin
        if (fpu_cmd_end) begin
          state_d = SETTLE;
          tmo_d   = '0;
        end else if (tmo_q == C_TMO_LAST) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b1;
          rsp_result_d = 32'd0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SETTLE: begin
        if (tmo_q == C_SETTLE_LAST) begin
          idx_d     = 4'd0;
          eng_start = 1'b1;
          eng_read  = 1'b1;
          eng_addr  = FPU_ADDR_R0;
          state_d   = RD_SETUP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RD_SETUP:  state_d = RD_STROBE;
      RD_STROBE: if (eng_last_strobe) state_d = RD_HOLD;
      RD_HOLD: begin
        if (eng_done) begin
          rsp_result_d[{idx_q[1:0], 3'b000} +: 8] = eng_rdata;
          if (idx_q == 4'd3) begin
            end_ack_d = 1'b1;
            state_d   = ACK;
          end else begin
            idx_d     = idx_q + 4'd1;
            eng_start = 1'b1;
            eng_read  = 1'b1;
            eng_addr  = FPU_ADDR_R0 + idx_d;
            state_d   = RD_SETUP;
          end
        end
      end
      ACK: begin
        tmo_d   = '0;
        state_d = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!fpu_cmd_end) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else if (tmo_q == C_TMO_LAST) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered handshake/result outputs
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      tmo_q        <= '0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      op_q         <= 4'd0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= 32'd0;
      end_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_result_q <= rsp_result_d;
      end_ack_q    <= end_ack_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_host_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fpu_host_sequencer                                      |
// | Purpose  : Directed self-checking bench with a small byte-bus FPU     |
// |            model and a bus-timing monitor.                            |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_fpu_host_sequencer;
  import pa_fpu::*;

  localparam int STROBE  = 2;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0, req_b = 32'd0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_result;
  logic [3:0]  fpu_addr;
  logic        fpu_cs, fpu_wr, fpu_rd, fpu_end_ack;
  logic [7:0]  fpu_data_out, fpu_data_in;
  logic        cmd_end;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fpu_host_sequencer #(.STROBE_CYCLES(STROBE), .SETTLE_CYCLES(SETTLE),
                       .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .fpu_addr(fpu_addr), .fpu_cs(fpu_cs), .fpu_wr(fpu_wr), .fpu_rd(fpu_rd),
    .fpu_data_out(fpu_data_out), .fpu_data_in(fpu_data_in),
    .fpu_cmd_end(cmd_end), .fpu_end_ack(fpu_end_ack)
  );

  // ---------------- FPU model ----------------
  logic [7:0]  regs [16];
  logic [31:0] model_res = 32'd0;
  logic        model_enable = 1'b1;
  int          busy_cnt;
  int          ack_count = 0;
  int          rsp_xfers = 0;

  // Known answers for the directed vectors; anything else reads back all-ones
  function automatic logic [31:0] fpu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == op_add && a == 32'h3FC00000 && b == 32'h40100000) return 32'h40700000;
    if (op == op_mul && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (op == op_sub && a == 32'h40A00000 && b == 32'h3F800000) return 32'h40800000;
    return 32'hFFFFFFFF;
  endfunction

  always @(posedge clk) begin
    if (!fpu_cs && !fpu_wr) begin
      regs[fpu_addr] <= fpu_data_out;
      if (fpu_addr == 4'd8)
        model_res <= fpu_ref(fpu_data_out[3:0], {regs[3], regs[2], regs[1], regs[0]},
                             {regs[7], regs[6], regs[5], regs[4]});
    end
  end

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cmd_end  <= 1'b0;
      busy_cnt <= 0;
    end else begin
      if (!fpu_cs && !fpu_wr && fpu_addr == 4'd8 && model_enable) busy_cnt <= 5;
      else if (busy_cnt > 1) busy_cnt <= busy_cnt - 1;
      else if (busy_cnt == 1) begin
        cmd_end  <= 1'b1;
        busy_cnt <= 0;
      end
      if (fpu_end_ack) cmd_end <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (arst_n && fpu_end_ack) ack_count++;
    if (arst_n && rsp_valid && rsp_ready) rsp_xfers++;
  end

  always_comb begin
    case (fpu_addr)
      4'd9:    fpu_data_in = model_res[7:0];
      4'd10:   fpu_data_in = model_res[15:8];
      4'd11:   fpu_data_in = model_res[23:16];
      4'd12:   fpu_data_in = model_res[31:24];
      default: fpu_data_in = 8'h00;
    endcase
  end

  // ---------------- bus timing monitor ----------------
  int          bus_acc = 0, bus_viol = 0;
  logic [11:0] wr_log [$];
  logic        prev_cs = 1'b1, in_strb = 1'b0, s_wr = 1'b0, s_bad = 1'b0;
  logic [3:0]  prev_addr = 4'd0, s_addr = 4'd0;
  logic [7:0]  prev_data = 8'd0, s_data = 8'd0;
  int          slen = 0;

  always @(negedge clk) begin
    if (!arst_n) begin
      in_strb = 1'b0;
    end else begin
      if (fpu_cs && (!fpu_wr || !fpu_rd)) bus_viol++;
      if (!fpu_cs) begin
        if (!in_strb) begin
          in_strb = 1'b1;
          slen    = 0;
          s_addr  = fpu_addr;
          s_data  = fpu_data_out;
          s_wr    = !fpu_wr;
          s_bad   = !(prev_cs && prev_addr == fpu_addr && (!s_wr || prev_data == fpu_data_out));
        end
        slen++;
        if (fpu_addr !== s_addr || (s_wr && fpu_data_out !== s_data) || fpu_wr == fpu_rd) s_bad = 1'b1;
      end else if (in_strb) begin
        in_strb = 1'b0;
        bus_acc++;
        if (slen != STROBE || fpu_addr !== s_addr || (s_wr && fpu_data_out !== s_data)) s_bad = 1'b1;
        if (s_bad) begin
          bus_viol++;
          $display("bus protocol violation: addr %h strobe_len %0d", s_addr, slen);
        end
        if (s_wr) wr_log.push_back({s_addr, s_data});
      end
    end
    prev_cs   = fpu_cs;
    prev_addr = fpu_addr;
    prev_data = fpu_data_out;
  end

  // ---------------- tasks ----------------
  task automatic send_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL req_ready_wait: req_ready=%b want 1", req_ready);
    else n_pass++;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    n_checks++;
    if (rsp_valid !== 1'b1) $display("FAIL %s rsp_wait: rsp_valid=%b want 1 after %0d cycles", name, rsp_valid, cycles);
    else n_pass++;
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int acks0 = ack_count;
    int acc0  = bus_acc;
    int viol0 = bus_viol;
    int cyc;
    send_req(op, a, b);
    n_checks++;
    if (fpu_cs !== 1'b1 || fpu_addr !== 4'd0 || fpu_data_out !== a[7:0] || req_ready !== 1'b0)
      $display("FAIL %s setup: cs=%b addr=%h data=%h rdy=%b want cs=1 addr=0 data=%h rdy=0",
               name, fpu_cs, fpu_addr, fpu_data_out, req_ready, a[7:0]);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (fpu_cs !== 1'b0 || fpu_wr !== 1'b0 || fpu_rd !== 1'b1)
      $display("FAIL %s first_strobe: cs=%b wr=%b rd=%b want 0 0 1", name, fpu_cs, fpu_wr, fpu_rd);
    else n_pass++;
    wait_rsp(name, cyc);
    n_checks++;
    if (rsp_result !== exp || rsp_err !== 1'b0)
      $display("FAIL %s result: got %h err=%b want %h err=0", name, rsp_result, rsp_err, exp);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL %s rsp_drop: rsp_valid=%b want 0", name, rsp_valid);
    else n_pass++;
    n_checks++;
    if (ack_count - acks0 != 1) $display("FAIL %s end_ack: pulses=%0d want 1", name, ack_count - acks0);
    else n_pass++;
    n_checks++;
    if (bus_acc - acc0 != 13 || bus_viol != viol0)
      $display("FAIL %s bus_timing: accesses=%0d violations=%0d want 13 and 0",
               name, bus_acc - acc0, bus_viol - viol0);
    else n_pass++;
  endtask

  task automatic test_reset();
    #1 arst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_result !== 32'd0 ||
        fpu_cs !== 1'b1 || fpu_wr !== 1'b1 || fpu_rd !== 1'b1 || fpu_end_ack !== 1'b0 ||
        fpu_addr !== 4'd0 || fpu_data_out !== 8'd0)
      $display("FAIL reset_values: rdy=%b v=%b e=%b r=%h cs=%b wr=%b rd=%b ack=%b addr=%h d=%h",
               req_ready, rsp_valid, rsp_err, rsp_result, fpu_cs, fpu_wr, fpu_rd, fpu_end_ack,
               fpu_addr, fpu_data_out);
    else n_pass++;
    arst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_release: req_ready=%b want 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_add();
    logic [7:0] exp_d [9] = '{8'h00, 8'h00, 8'hC0, 8'h3F, 8'h00, 8'h00, 8'h10, 8'h40, 8'h00};
    int start = wr_log.size();
    int bad   = 0;
    run_op("add", op_add, 32'h3FC00000, 32'h40100000, 32'h40700000);
    n_checks++;
    if (wr_log.size() - start != 9) $display("FAIL add write_count: got %0d want 9", wr_log.size() - start);
    else n_pass++;
    for (int i = 0; i < 9 && start + i < wr_log.size(); i++) begin
      if (wr_log[start + i] !== {4'(i), exp_d[i]}) begin
        bad++;
        $display("FAIL add write_%0d: got addr/data %h want %h", i, wr_log[start + i], {4'(i), exp_d[i]});
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL add write_sequence: %0d wrong writes, want 0", bad);
    else n_pass++;
  endtask

  task automatic test_mul();
    run_op("mul", op_mul, 32'h40000000, 32'h40400000, 32'h40C00000);
  endtask

  task automatic test_sub();
    run_op("sub", op_sub, 32'h40A00000, 32'h3F800000, 32'h40800000);
  endtask

  task automatic test_timeout();
    int acks0 = ack_count;
    int cyc;
    model_enable = 1'b0;
    send_req(op_add, 32'h3FC00000, 32'h40100000);
    wait_rsp("timeout", cyc);
    n_checks++;
    if (cyc != 36 + TIMEOUT) $display("FAIL timeout latency: got %0d cycles want %0d", cyc, 36 + TIMEOUT);
    else n_pass++;
    n_checks++;
    if (rsp_err !== 1'b1 || rsp_result !== 32'd0)
      $display("FAIL timeout response: err=%b result=%h want err=1 result=0", rsp_err, rsp_result);
    else n_pass++;
    n_checks++;
    if (ack_count != acks0) $display("FAIL timeout end_ack: pulses=%0d want 0", ack_count - acks0);
    else n_pass++;
    @(negedge clk);
    model_enable = 1'b1;
    run_op("after_timeout", op_add, 32'h3FC00000, 32'h40100000, 32'h40700000);
  endtask

  task automatic test_backpressure();
    int cyc;
    int x0;
    rsp_ready = 1'b0;
    send_req(op_mul, 32'h40000000, 32'h40400000);
    wait_rsp("backpressure", cyc);
    x0 = rsp_xfers;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'h40C00000 || rsp_err !== 1'b0 || req_ready !== 1'b0)
        $display("FAIL backpressure hold_%0d: v=%b r=%h e=%b rdy=%b want 1 40c00000 0 0",
                 i, rsp_valid, rsp_result, rsp_err, req_ready);
      else n_pass++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_xfers - x0 != 1)
      $display("FAIL backpressure release: v=%b rdy=%b transfers=%0d want 0 0 1",
               rsp_valid, req_ready, rsp_xfers - x0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL backpressure req_ready_return: got %b want 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int   falls = 0;
    int   n = 0;
    logic pcs = 1'b1;
    send_req(op_add, 32'h3FC00000, 32'h40100000);
    pcs = fpu_cs;
    while (falls < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (!fpu_cs && pcs) falls++;
      pcs = fpu_cs;
    end
    n_checks++;
    if (falls != 3) $display("FAIL reset_mid find_strobe: saw %0d strobes want 3", falls);
    else n_pass++;
    arst_n = 1'b0;
    #1;
    n_checks++;
    if (fpu_cs !== 1'b1 || fpu_wr !== 1'b1)
      $display("FAIL reset_mid async_strobes: cs=%b wr=%b want 1 1", fpu_cs, fpu_wr);
    else n_pass++;
    n_checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_result !== 32'd0 ||
        fpu_rd !== 1'b1 || fpu_end_ack !== 1'b0 || fpu_addr !== 4'd0 || fpu_data_out !== 8'd0)
      $display("FAIL reset_mid values: rdy=%b v=%b e=%b r=%h rd=%b ack=%b addr=%h d=%h",
               req_ready, rsp_valid, rsp_err, rsp_result, fpu_rd, fpu_end_ack, fpu_addr, fpu_data_out);
    else n_pass++;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_mid release: req_ready=%b want 1", req_ready);
    else n_pass++;
    run_op("add_after_reset", op_add, 32'h3FC00000, 32'h40100000, 32'h40700000);
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_sub();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case a wait loop is ever bypassed
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
